// File: rtl/mul_iter_unit.sv
// Iterative radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// One FA_32bit adder is reused across 32 CALC iterations; a FIX cycle applies the sign.

module FA_32bit (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Cin,
  output logic [31:0] Sum,
  output logic        Cout
);

  logic [32:0] c;

  assign c[0] = Cin;

  genvar g;
  generate
    for (g = 0; g < 32; g++) begin : g_bit
      assign Sum[g]   = A[g] ^ B[g] ^ c[g];
      assign c[g+1]   = (A[g] & B[g]) | (A[g] & c[g]) | (B[g] & c[g]);
    end
  endgenerate

  assign Cout = c[32];

endmodule

module mul_iter_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic            i_kill,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy
);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t state, state_n;

  logic [XLEN-1:0]  hi, lo, mcand, result_q;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_q;
  logic             neg_q;

  // Unsigned magnitude of an operand; the most negative value maps onto itself.
  function automatic logic [XLEN-1:0] magnitude(input logic signed [XLEN-1:0] x,
                                                input logic is_signed);
    logic signed [XLEN-1:0] neg;
    neg = -x;
    if (is_signed && (x < 0))
      return $unsigned(neg);
    else
      return $unsigned(x);
  endfunction

  function automatic logic [2*XLEN-1:0] twos_neg(input logic [2*XLEN-1:0] v);
    return ~v + {{(2*XLEN-1){1'b0}}, 1'b1};
  endfunction

  logic signed [XLEN-1:0] rs1_s, rs2_s;
  logic                   sgn1, sgn2;
  logic [XLEN-1:0]        mag1, mag2;

  always_comb begin
    rs1_s = i_rs1;
    rs2_s = i_rs2;
    sgn1  = ((i_op == OP_MULH) || (i_op == OP_MULHSU)) && (rs1_s < 0);
    sgn2  = (i_op == OP_MULH) && (rs2_s < 0);
    mag1  = magnitude(rs1_s, (i_op == OP_MULH) || (i_op == OP_MULHSU));
    mag2  = magnitude(rs2_s, (i_op == OP_MULH));
  end

  // Adder stage: accumulate hi with the multiplicand when the current multiplier bit is set.
  logic [XLEN-1:0] fa_a, fa_b, fa_sum;
  logic            fa_cout;

  assign fa_a = hi;
  assign fa_b = lo[0] ? mcand : '0;

  FA_32bit u_fa (
    .A    (fa_a),
    .B    (fa_b),
    .Cin  (1'b0),
    .Sum  (fa_sum),
    .Cout (fa_cout)
  );

  logic [2*XLEN-1:0] prod_fix;

  always_comb begin
    prod_fix = {hi, lo};
    if (neg_q)
      prod_fix = twos_neg({hi, lo});
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (i_kill) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: if (i_valid) state_n = CALC;
        CALC: if (cnt == CNT_W'(XLEN-1)) state_n = FIX;
        FIX:  state_n = DONE;
        DONE: if (i_ready) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Datapath state; a kill freezes everything so the last result survives the flush.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hi       <= '0;
      lo       <= '0;
      mcand    <= '0;
      cnt      <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else if (!i_kill) begin
      unique case (state)
        IDLE: begin
          if (i_valid) begin
            op_q  <= i_op;
            mcand <= mag1;
            lo    <= mag2;
            hi    <= '0;
            cnt   <= '0;
            neg_q <= sgn1 ^ sgn2;
          end
        end
        CALC: begin
          {hi, lo} <= {fa_cout, fa_sum, lo[XLEN-1:1]};
          cnt      <= cnt + CNT_W'(1);
        end
        FIX: begin
          {hi, lo} <= prod_fix;
          result_q <= (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end
        default: ;
      endcase
    end
  end

  assign o_ready  = (state == IDLE);
  assign o_valid  = (state == DONE);
  assign o_busy   = (state == CALC) || (state == FIX);
  assign o_result = result_q;

endmodule

// File: tb/tb_mul_iter_unit.sv
// Directed bench for mul_iter_unit: products, latency, backpressure, reset and kill.

module tb_mul_iter_unit;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [1:0]  i_op;
  logic [31:0] i_rs1;
  logic [31:0] i_rs2;
  logic        i_kill;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic        o_busy;

  int total = 0;
  int bad   = 0;

  mul_iter_unit dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_op     (i_op),
    .i_rs1    (i_rs1),
    .i_rs2    (i_rs2),
    .i_kill   (i_kill),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_busy   (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request and return the cycles to o_valid and the busy-cycle count.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int busy);
    @(negedge i_clk);
    i_op = op; i_rs1 = a; i_rs2 = b; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    lat = 0; busy = 0;
    while (!o_valid && lat < 100) begin
      if (o_busy) busy++;
      @(posedge i_clk); #1;
      lat++;
    end
  endtask

  task automatic drain();
    @(negedge i_clk);
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int lat, busy;
    issue(op, a, b, lat, busy);
    chk({tag, "_lat"}, 32'(lat), 32'd33);
    chk(tag, o_result, exp);
    drain();
    chk({tag, "_rdy"}, {31'd0, o_ready}, 32'd1);
  endtask

  initial begin
    int lat, busy, vcount;
    i_rst_n = 1'b0; i_valid = 1'b0; i_op = 2'b00; i_rs1 = '0; i_rs2 = '0;
    i_kill = 1'b0; i_ready = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_ready",  {31'd0, o_ready}, 32'd1);
    chk("rst_valid",  {31'd0, o_valid}, 32'd0);
    chk("rst_busy",   {31'd0, o_busy},  32'd0);
    chk("rst_result", o_result, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    issue(2'b00, 32'd7, 32'd6, lat, busy);
    chk("mul7x6_lat",  32'(lat),  32'd33);
    chk("mul7x6_busy", 32'(busy), 32'd33);
    chk("mul7x6",      o_result,  32'h0000002A);
    drain();

    run_op("mulhu_ff",   2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("mul_ff",     2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
    run_op("mulh_min",   2'b01, 32'h80000000, 32'h80000000, 32'h40000000);
    run_op("mulh_m1x1",  2'b01, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF);
    run_op("mulh_0xm1",  2'b01, 32'h00000000, 32'hFFFFFFFF, 32'h00000000);
    run_op("mulhsu_ff",  2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op("mulhu_ff2",  2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("mulh_neg",   2'b01, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF);
    run_op("mul_neg",    2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1);

    // Backpressure plus an ignored second request during CALC.
    @(negedge i_clk);
    i_op = 2'b00; i_rs1 = 32'd100; i_rs2 = 32'd3; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (5) @(posedge i_clk);
    @(negedge i_clk);
    i_op = 2'b11; i_rs1 = 32'd9; i_rs2 = 32'd9; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    lat = 0;
    while (!o_valid && lat < 100) begin
      @(posedge i_clk); #1;
      lat++;
    end
    chk("bp_lat", 32'(lat), 32'd27);
    chk("bp_res", o_result, 32'd300);
    repeat (5) @(posedge i_clk);
    #1;
    chk("bp_hold_valid", {31'd0, o_valid}, 32'd1);
    chk("bp_hold_res",   o_result, 32'd300);
    chk("bp_hold_ready", {31'd0, o_ready}, 32'd0);
    drain();
    vcount = 0;
    repeat (40) begin
      @(posedge i_clk); #1;
      if (o_valid) vcount++;
    end
    chk("bp_one_result", 32'(vcount), 32'd0);
    chk("bp_res_kept",   o_result, 32'd300);

    // Asynchronous reset mid-calculation.
    @(negedge i_clk);
    i_op = 2'b00; i_rs1 = 32'd11; i_rs2 = 32'd13; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (10) @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("arst_busy",   {31'd0, o_busy},  32'd0);
    chk("arst_ready",  {31'd0, o_ready}, 32'd1);
    chk("arst_valid",  {31'd0, o_valid}, 32'd0);
    chk("arst_result", o_result, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    run_op("mul3x5", 2'b00, 32'd3, 32'd5, 32'h0000000F);

    // Kill at iteration 20.
    @(negedge i_clk);
    i_op = 2'b11; i_rs1 = 32'd50; i_rs2 = 32'd50; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (19) @(posedge i_clk);
    @(negedge i_clk);
    chk("kill_busy_pre", {31'd0, o_busy}, 32'd1);
    i_kill = 1'b1;
    @(posedge i_clk); #1;
    i_kill = 1'b0;
    chk("kill_ready", {31'd0, o_ready}, 32'd1);
    chk("kill_busy",  {31'd0, o_busy},  32'd0);
    vcount = 0;
    repeat (40) begin
      @(posedge i_clk); #1;
      if (o_valid) vcount++;
    end
    chk("kill_no_valid", 32'(vcount), 32'd0);
    chk("kill_res_kept", o_result, 32'h0000000F);

    // Kill in IDLE beats a simultaneous request.
    @(negedge i_clk);
    i_op = 2'b00; i_rs1 = 32'd2; i_rs2 = 32'd2; i_valid = 1'b1; i_kill = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_kill = 1'b0;
    chk("kill_idle_ready", {31'd0, o_ready}, 32'd1);
    chk("kill_idle_busy",  {31'd0, o_busy},  32'd0);

    // Kill in DONE beats i_ready and keeps the result.
    issue(2'b00, 32'd4, 32'd4, lat, busy);
    chk("kd_res", o_result, 32'd16);
    @(negedge i_clk);
    i_ready = 1'b1; i_kill = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0; i_kill = 1'b0;
    chk("kd_valid", {31'd0, o_valid}, 32'd0);
    chk("kd_ready", {31'd0, o_ready}, 32'd1);
    chk("kd_res_kept", o_result, 32'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
